// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the 5-stage MIPS pipeline:
//   - DATA_W / REG_ADDR_W : default datapath and register-specifier widths
//   - ALU_OP_*            : 2-bit ALU operation classes driven by decode
//   - ctrl_t              : packed control bundle carried from ID/EX onward
//                           (the EX/MEM and MEM/WB stages keep the subset
//                           of fields they still need)
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    // ALU operation classes
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;  // lw / sw address add
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;  // beq compare
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;  // decode the funct field

    typedef struct packed {
        logic       alu_src;
        logic       reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect
// Purely combinational hazard/bypass logic for the ID/EX stage.
//   Inputs : EX-side load info (valid, mem_read, rt), ID-side register
//            specifiers (valid, rs, rt, uses_rt), branch flush, and the
//            WB-stage register-file write port (enable, destination).
//   Outputs: o_stall     - load-use hazard: hold ID and insert a bubble
//            o_bypass_rs - take WB write data instead of rs read data
//            o_bypass_rt - take WB write data instead of rt read data
// Register $0 never causes a stall or a bypass.
module hazard_detect #(
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rt_addr,
    input  logic                  i_id_valid,
    input  logic                  i_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] i_id_rs_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rt_addr,
    input  logic                  i_flush,
    input  logic                  i_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    output logic                  o_stall,
    output logic                  o_bypass_rs,
    output logic                  o_bypass_rt
);

    logic w_load_in_ex;
    logic w_rs_dep;
    logic w_rt_dep;
    logic w_wb_active;

    // A load in EX whose destination is a real register
    assign w_load_in_ex = i_ex_valid & i_ex_mem_read & (|i_ex_rt_addr);

    assign w_rs_dep = (i_ex_rt_addr == i_id_rs_addr);
    // rt only matters when the ID instruction actually reads it; for
    // I-type ALU ops and loads rt is the destination, not a source.
    assign w_rt_dep = i_id_uses_rt & (i_ex_rt_addr == i_id_rt_addr);

    // A flush kills the ID instruction anyway, so stalling it is pointless.
    assign o_stall = w_load_in_ex & i_id_valid & (w_rs_dep | w_rt_dep) & ~i_flush;

    // Register file write-through: WB writes at the same edge ID/EX
    // captures, so the register-file read in ID is stale for that register.
    assign w_wb_active = i_wb_reg_write & (|i_wb_rd_addr);
    assign o_bypass_rs = w_wb_active & (i_wb_rd_addr == i_id_rs_addr);
    assign o_bypass_rt = w_wb_active & (i_wb_rd_addr == i_id_rt_addr);

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core.
//   clk, reset           : clock and asynchronous active-high reset
//   id_*                 : decoded instruction (operands, specifiers, controls)
//   wb_reg_write/rd/data : WB register-file write port, used for write-through
//   flush                : taken branch in EX, kill the instruction in ID
//   stall_id             : combinational load-use stall request to PC / IF/ID
//   ex_*                 : registered copies presented to the execute stage
//   stall_count,
//   flush_count          : saturating performance-debug event counters
// A flush or a stall turns the EX slot into a bubble: valid and all control
// bits cleared, data/address fields left as they were.
module id_ex_stage #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // decode stage
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_sign_ext,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [5:0]            id_funct,
    input  logic                  id_uses_rt,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_reg_write,
    input  logic                  id_branch,
    input  logic [1:0]            id_alu_op,
    // write-back port
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0]     wb_data,
    // branch flush
    input  logic                  flush,
    // hazard output
    output logic                  stall_id,
    // execute stage
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [DATA_W-1:0]     ex_sign_ext,
    output logic [REG_ADDR_W-1:0] ex_rs_addr,
    output logic [REG_ADDR_W-1:0] ex_rt_addr,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic [5:0]            ex_funct,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_reg_write,
    output logic                  ex_branch,
    // performance counters
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    import mips_pkg::*;

    // EX register
    logic                  r_valid;
    ctrl_t                 r_ctrl;
    logic [DATA_W-1:0]     r_pc;
    logic [DATA_W-1:0]     r_rs_data;
    logic [DATA_W-1:0]     r_rt_data;
    logic [DATA_W-1:0]     r_sign_ext;
    logic [REG_ADDR_W-1:0] r_rs_addr;
    logic [REG_ADDR_W-1:0] r_rt_addr;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [5:0]            r_funct;
    logic [CNT_W-1:0]      r_stall_count;
    logic [CNT_W-1:0]      r_flush_count;

    logic                  w_stall;
    logic                  w_bypass_rs;
    logic                  w_bypass_rt;
    logic                  w_bubble;
    ctrl_t                 w_id_ctrl;
    logic [DATA_W-1:0]     w_rs_data;
    logic [DATA_W-1:0]     w_rt_data;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .i_ex_valid     (r_valid),
        .i_ex_mem_read  (r_ctrl.mem_read),
        .i_ex_rt_addr   (r_rt_addr),
        .i_id_valid     (id_valid),
        .i_id_uses_rt   (id_uses_rt),
        .i_id_rs_addr   (id_rs_addr),
        .i_id_rt_addr   (id_rt_addr),
        .i_flush        (flush),
        .i_wb_reg_write (wb_reg_write),
        .i_wb_rd_addr   (wb_rd_addr),
        .o_stall        (w_stall),
        .o_bypass_rs    (w_bypass_rs),
        .o_bypass_rt    (w_bypass_rt)
    );

    assign w_bubble  = flush | w_stall;
    assign w_rs_data = w_bypass_rs ? wb_data : id_rs_data;
    assign w_rt_data = w_bypass_rt ? wb_data : id_rt_data;

    always_comb begin
        w_id_ctrl            = '0;
        w_id_ctrl.alu_src    = id_alu_src;
        w_id_ctrl.reg_dst    = id_reg_dst;
        w_id_ctrl.mem_read   = id_mem_read;
        w_id_ctrl.mem_write  = id_mem_write;
        w_id_ctrl.mem_to_reg = id_mem_to_reg;
        w_id_ctrl.reg_write  = id_reg_write;
        w_id_ctrl.branch     = id_branch;
        w_id_ctrl.alu_op     = id_alu_op;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_ctrl        <= '0;
            r_pc          <= '0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_sign_ext    <= '0;
            r_rs_addr     <= '0;
            r_rt_addr     <= '0;
            r_rd_addr     <= '0;
            r_funct       <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_bubble) begin
                // data/address fields are don't-care in a bubble; holding
                // them avoids needless toggling into the ALU
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else begin
                r_valid    <= id_valid;
                r_ctrl     <= w_id_ctrl;
                r_pc       <= id_pc;
                r_rs_data  <= w_rs_data;
                r_rt_data  <= w_rt_data;
                r_sign_ext <= id_sign_ext;
                r_rs_addr  <= id_rs_addr;
                r_rt_addr  <= id_rt_addr;
                r_rd_addr  <= id_rd_addr;
                r_funct    <= id_funct;
            end

            // w_stall is already masked by flush, so a simultaneous
            // flush+hazard counts only as a flush
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_id      = w_stall;
    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_rs_data    = r_rs_data;
    assign ex_rt_data    = r_rt_data;
    assign ex_sign_ext   = r_sign_ext;
    assign ex_rs_addr    = r_rs_addr;
    assign ex_rt_addr    = r_rt_addr;
    assign ex_rd_addr    = r_rd_addr;
    assign ex_funct      = r_funct;
    assign ex_alu_op     = r_ctrl.alu_op;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_reg_dst    = r_ctrl.reg_dst;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_branch     = r_ctrl.branch;
    assign stall_count   = r_stall_count;
    assign flush_count   = r_flush_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Directed self-checking bench for id_ex_stage. Counters are built narrow
// so their saturation can be reached in a handful of cycles.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [DW-1:0] id_pc, id_rs_data, id_rt_data, id_sign_ext;
    logic [AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr;
    logic [5:0]    id_funct;
    logic          id_uses_rt, id_alu_src, id_reg_dst, id_mem_read, id_mem_write;
    logic          id_mem_to_reg, id_reg_write, id_branch;
    logic [1:0]    id_alu_op;
    logic          wb_reg_write;
    logic [AW-1:0] wb_rd_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          stall_id, ex_valid;
    logic [DW-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_sign_ext;
    logic [AW-1:0] ex_rs_addr, ex_rt_addr, ex_rd_addr;
    logic [5:0]    ex_funct;
    logic [1:0]    ex_alu_op;
    logic          ex_alu_src, ex_reg_dst, ex_mem_read, ex_mem_write;
    logic          ex_mem_to_reg, ex_reg_write, ex_branch;
    logic [CW-1:0] stall_count, flush_count;

    int n_pass  = 0;
    int n_total = 0;

    id_ex_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_sign_ext(id_sign_ext),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_funct(id_funct), .id_uses_rt(id_uses_rt), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
        .id_branch(id_branch), .id_alu_op(id_alu_op),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_sign_ext(ex_sign_ext), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_rd_addr(ex_rd_addr), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one decoded instruction. reg_dst/funct follow from R-type,
    // mem_to_reg from mem_read.
    task automatic drive_id(input logic v, input logic [AW-1:0] rs, rt, rd,
                            input logic [DW-1:0] rsd, rtd, pc, imm,
                            input logic uses_rt, mem_rd, mem_wr, reg_wr, alu_src,
                            input logic [1:0] alu_op);
        id_valid      = v;
        id_rs_addr    = rs;
        id_rt_addr    = rt;
        id_rd_addr    = rd;
        id_rs_data    = rsd;
        id_rt_data    = rtd;
        id_pc         = pc;
        id_sign_ext   = imm;
        id_uses_rt    = uses_rt;
        id_mem_read   = mem_rd;
        id_mem_to_reg = mem_rd;
        id_mem_write  = mem_wr;
        id_reg_write  = reg_wr;
        id_alu_src    = alu_src;
        id_alu_op     = alu_op;
        id_branch     = 1'b0;
        id_reg_dst    = (alu_op == 2'b10);
        id_funct      = (alu_op == 2'b10) ? 6'h20 : 6'h00;
    endtask

    // lw $rt, imm($1)
    task automatic drive_lw(input logic [AW-1:0] rt);
        drive_id(1'b1, 5'd1, rt, 5'd0, 32'h100, 32'h0, 32'h1000, 32'h4,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    endtask

    task automatic test_reset();
        // drive a busy instruction while reset is held: nothing may be captured
        reset = 1'b1;
        flush = 1'b0;
        wb_reg_write = 1'b0; wb_rd_addr = '0; wb_data = '0;
        drive_lw(5'd2);
        tick(); tick();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", ex_valid); else n_pass++;
        n_total++; if (ex_mem_read !== 1'b0) $display("FAIL rst_mem_read: got %0h want 0", ex_mem_read); else n_pass++;
        n_total++; if (ex_pc !== 32'h0) $display("FAIL rst_pc: got %0h want 0", ex_pc); else n_pass++;
        n_total++; if (stall_id !== 1'b0) $display("FAIL rst_stall: got %0h want 0", stall_id); else n_pass++;
        n_total++; if (stall_count !== 4'h0 || flush_count !== 4'h0)
            $display("FAIL rst_counters: got %0h/%0h want 0/0", stall_count, flush_count); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_capture();
        // add $5, $3, $4 with rs=5, rt=7
        drive_id(1'b1, 5'd3, 5'd4, 5'd5, 32'd5, 32'd7, 32'h44, 32'h2820,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        tick();
        n_total++; if (ex_valid !== 1'b1) $display("FAIL cap_valid: got %0h want 1", ex_valid); else n_pass++;
        n_total++; if (ex_rs_data !== 32'd5) $display("FAIL cap_rs_data: got %0h want 5", ex_rs_data); else n_pass++;
        n_total++; if (ex_rt_data !== 32'd7) $display("FAIL cap_rt_data: got %0h want 7", ex_rt_data); else n_pass++;
        n_total++; if (ex_alu_op !== 2'b10) $display("FAIL cap_alu_op: got %0h want 2", ex_alu_op); else n_pass++;
        n_total++; if (ex_rd_addr !== 5'd5 || ex_reg_dst !== 1'b1 || ex_reg_write !== 1'b1)
            $display("FAIL cap_dst: got rd=%0h dst=%0h wr=%0h want 5/1/1", ex_rd_addr, ex_reg_dst, ex_reg_write); else n_pass++;
        n_total++; if (ex_pc !== 32'h44 || ex_sign_ext !== 32'h2820 || ex_funct !== 6'h20)
            $display("FAIL cap_fields: got pc=%0h imm=%0h fn=%0h want 44/2820/20", ex_pc, ex_sign_ext, ex_funct); else n_pass++;
        n_total++; if (stall_id !== 1'b0) $display("FAIL cap_stall: got %0h want 0", stall_id); else n_pass++;
    endtask

    task automatic test_back_to_back();
        // sub $6,$1,$2 immediately followed by lw $9 -- one capture per edge
        drive_id(1'b1, 5'd1, 5'd2, 5'd6, 32'h30, 32'h10, 32'h48, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        tick();
        n_total++; if (ex_rs_data !== 32'h30 || ex_rd_addr !== 5'd6)
            $display("FAIL b2b_first: got rs=%0h rd=%0h want 30/6", ex_rs_data, ex_rd_addr); else n_pass++;
        drive_lw(5'd9);
        tick();
        n_total++; if (ex_mem_read !== 1'b1 || ex_rt_addr !== 5'd9 || ex_alu_src !== 1'b1 || ex_mem_to_reg !== 1'b1)
            $display("FAIL b2b_second: got mr=%0h rt=%0h src=%0h m2r=%0h want 1/9/1/1",
                     ex_mem_read, ex_rt_addr, ex_alu_src, ex_mem_to_reg); else n_pass++;
        // next instruction reads neither $9 source-wise
        drive_id(1'b1, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'h50, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        #1;
        n_total++; if (stall_id !== 1'b0) $display("FAIL b2b_nostall: got %0h want 0", stall_id); else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        drive_lw(5'd2);
        tick();
        // add $7, $2, $3 in ID while lw $2 is in EX
        drive_id(1'b1, 5'd2, 5'd3, 5'd7, 32'd11, 32'd12, 32'h58, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        #1;
        n_total++; if (stall_id !== 1'b1) $display("FAIL lu_stall: got %0h want 1", stall_id); else n_pass++;
        tick();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_valid: got %0h want 0", ex_valid); else n_pass++;
        n_total++; if ({ex_alu_src, ex_reg_dst, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                        ex_reg_write, ex_branch, ex_alu_op} !== 9'h0)
            $display("FAIL lu_bubble_ctrl: got %0h want 0", {ex_alu_src, ex_reg_dst, ex_mem_read,
                     ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_alu_op}); else n_pass++;
        n_total++; if (stall_id !== 1'b0) $display("FAIL lu_stall_release: got %0h want 0", stall_id); else n_pass++;
        n_total++; if (stall_count !== 4'd1) $display("FAIL lu_stall_count: got %0h want 1", stall_count); else n_pass++;
        tick();
        n_total++; if (ex_valid !== 1'b1 || ex_rs_data !== 32'd11)
            $display("FAIL lu_resume: got v=%0h rs=%0h want 1/b", ex_valid, ex_rs_data); else n_pass++;
    endtask

    task automatic test_rt_zero();
        drive_lw(5'd0);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'h60, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        #1;
        n_total++; if (stall_id !== 1'b0) $display("FAIL rz_zero_reg: got %0h want 0", stall_id); else n_pass++;
        drive_lw(5'd5);
        tick();
        // addi $5, $1, 3: rt is a destination, not a source
        drive_id(1'b1, 5'd1, 5'd5, 5'd0, 32'd0, 32'd0, 32'h68, 32'h3,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
        #1;
        n_total++; if (stall_id !== 1'b0) $display("FAIL rz_addi_rt: got %0h want 0", stall_id); else n_pass++;
        // sw $5, 0($1): rt is a source
        drive_id(1'b1, 5'd1, 5'd5, 5'd0, 32'd0, 32'd0, 32'h68, 32'h0,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        #1;
        n_total++; if (stall_id !== 1'b1) $display("FAIL rz_sw_rt: got %0h want 1", stall_id); else n_pass++;
        drive_id(1'b0, 5'd1, 5'd5, 5'd0, 32'd0, 32'd0, 32'h68, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        n_total++; if (stall_id !== 1'b0) $display("FAIL rz_invalid_id: got %0h want 0", stall_id); else n_pass++;
        tick();
        n_total++; if (ex_valid !== 1'b0 || stall_count !== 4'd1)
            $display("FAIL rz_idle: got v=%0h sc=%0h want 0/1", ex_valid, stall_count); else n_pass++;
    endtask

    task automatic test_bypass();
        drive_id(1'b1, 5'd3, 5'd4, 5'd5, 32'h2222, 32'h1111, 32'h70, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        wb_reg_write = 1'b1; wb_rd_addr = 5'd4; wb_data = 32'hDEAD;
        tick();
        n_total++; if (ex_rt_data !== 32'hDEAD) $display("FAIL byp_rt: got %0h want dead", ex_rt_data); else n_pass++;
        n_total++; if (ex_rs_data !== 32'h2222) $display("FAIL byp_rs_untouched: got %0h want 2222", ex_rs_data); else n_pass++;
        wb_rd_addr = 5'd0;
        tick();
        n_total++; if (ex_rt_data !== 32'h1111) $display("FAIL byp_zero: got %0h want 1111", ex_rt_data); else n_pass++;
        wb_rd_addr = 5'd3;
        tick();
        n_total++; if (ex_rs_data !== 32'hDEAD || ex_rt_data !== 32'h1111)
            $display("FAIL byp_rs: got %0h/%0h want dead/1111", ex_rs_data, ex_rt_data); else n_pass++;
        wb_reg_write = 1'b0; wb_rd_addr = 5'd4;
        tick();
        n_total++; if (ex_rt_data !== 32'h1111) $display("FAIL byp_no_write: got %0h want 1111", ex_rt_data); else n_pass++;
        wb_rd_addr = 5'd0; wb_data = '0;
    endtask

    task automatic test_flush_vs_stall();
        drive_lw(5'd2);
        tick();
        drive_id(1'b1, 5'd2, 5'd3, 5'd7, 32'd1, 32'd2, 32'h80, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        flush = 1'b1;
        #1;
        n_total++; if (stall_id !== 1'b0) $display("FAIL fl_stall_masked: got %0h want 0", stall_id); else n_pass++;
        tick();
        n_total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0)
            $display("FAIL fl_bubble: got v=%0h wr=%0h want 0/0", ex_valid, ex_reg_write); else n_pass++;
        n_total++; if (flush_count !== 4'd1) $display("FAIL fl_count: got %0h want 1", flush_count); else n_pass++;
        n_total++; if (stall_count !== 4'd1) $display("FAIL fl_stall_count: got %0h want 1", stall_count); else n_pass++;
        // 13 more flushes: 14, still below the 4-bit ceiling
        for (int i = 0; i < 13; i++) tick();
        n_total++; if (flush_count !== 4'd14) $display("FAIL fl_count_14: got %0h want e", flush_count); else n_pass++;
        // 2^CW+3 flushes in total, well past saturation
        for (int i = 0; i < (1 << CW) + 3 - 14; i++) tick();
        n_total++; if (flush_count !== 4'hF) $display("FAIL fl_saturate: got %0h want f", flush_count); else n_pass++;
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        drive_lw(5'd2);
        tick();
        drive_id(1'b1, 5'd2, 5'd3, 5'd7, 32'd1, 32'd2, 32'h90, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        #1;
        n_total++; if (stall_id !== 1'b1) $display("FAIL ar_pre_stall: got %0h want 1", stall_id); else n_pass++;
        #1 reset = 1'b1;   // between edges
        #1;
        n_total++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rt_addr !== 5'd0 || ex_pc !== 32'h0)
            $display("FAIL ar_immediate: got v=%0h mr=%0h rt=%0h pc=%0h want 0/0/0/0",
                     ex_valid, ex_mem_read, ex_rt_addr, ex_pc); else n_pass++;
        n_total++; if (stall_id !== 1'b0) $display("FAIL ar_stall: got %0h want 0", stall_id); else n_pass++;
        n_total++; if (stall_count !== 4'd0 || flush_count !== 4'd0)
            $display("FAIL ar_counters: got %0h/%0h want 0/0", stall_count, flush_count); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        drive_id(1'b1, 5'd3, 5'd4, 5'd5, 32'd9, 32'd8, 32'h40, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
        tick();
        n_total++; if (ex_valid !== 1'b1 || ex_rs_data !== 32'd9 || ex_rt_data !== 32'd8 || ex_pc !== 32'h40)
            $display("FAIL ar_resume: got v=%0h rs=%0h rt=%0h pc=%0h want 1/9/8/40",
                     ex_valid, ex_rs_data, ex_rt_data, ex_pc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_back_to_back();
        test_load_use();
        test_rt_zero();
        test_bypass();
        test_flush_vs_stall();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
